cpu_core: RTL
=============

// Module: cpu_core
// PURPOSE
//  4-bit execute core; consumer of the 16x8 program ROM. Drives ROM ADDR from its PC, takes
//  DATA (opcode[7:4], Im[3:0]) and executes one instruction per execute tick.
//  Holds A, B, OUT, PC and carry flag C. Top level wires ADDR->ROM, IN to switches, OUT to LEDs.
// PARAMETERS
//  CLK_DIV  1  CLK cycles per execute tick (>=1); 1 = one instruction per enabled cycle
// PORTS
//  CLK      in   1  system clock; all state updates on rising edge
//  RST      in   1  synchronous, active-high reset
//  RUN      in   1  1 = tick counter advances; 0 = core frozen (all state held)
//  ADDR     out  4  instruction address to ROM (= PC, registered)
//  DATA     in   8  instruction from ROM, combinational on ADDR
//  IN       in   4  input port, sampled at the execute tick
//  OUT      out  4  output port register
//  CARRY    out  1  carry flag C
//  HALT     out  1  1 while PC is stuck on a self-jump
//  REG_A    out  4  debug view of A
//  REG_B    out  4  debug view of B
// BEHAVIOUR
//  Reset: on RST=1 at edge: PC, A, B, OUT, C, HALT, tick counter all 0. RST wins over RUN/tick.
//  Tick: counter 0..CLK_DIV-1, increments only while RUN=1, wraps to 0.
//   Tick asserted in a cycle with RUN=1 and counter==CLK_DIV-1.
//   RUN=0: counter holds; it does not clear.
//  Execute: on a tick edge, decode the DATA present in that cycle.
//   Results are visible the next cycle. Non-tick cycles change nothing but the counter.
//  Opcodes; Im = DATA[3:0]; PC+1 wraps 4'hF -> 4'h0:
//   0000 ADD A,Im: A <= A+Im; C <= carry-out
//   0101 ADD B,Im: B <= B+Im; C <= carry-out
//   0011 MOV A,Im
//   0111 MOV B,Im
//   0001 MOV A,B
//   0100 MOV B,A
//   0010 IN A: A <= IN
//   0110 IN B: B <= IN
//   1001 OUT B: OUT <= B
//   1011 OUT Im: OUT <= Im
//   1111 JMP Im: PC <= Im
//   1110 JNC Im: PC <= (C==0) ? Im : PC+1
//   1000, 1010, 1100, 1101: NOP
//  Every opcode except JMP/JNC sets PC <= PC+1.
//  C: written on every tick; ADD -> carry-out of 4-bit sum, all other opcodes (incl. NOP, JMP, JNC) -> 0.
//   JNC tests C as it stood before the tick.
//  Arithmetic: 4-bit modulo; carry = bit 4 of the 5-bit sum. Registers not named by the opcode hold.
//  HALT: set on a tick where the next PC equals the current PC.
//   Covers JMP to self, and JNC to self with C=0.
//   Cleared on any tick where PC changes, and on RST.
//  RST mid-instruction: pending tick discarded; execution restarts at PC=0 with counter=0.
// TESTING
//  1 RST held 2 cycles, CLK_DIV=1 -> ADDR=0, OUT=0, A=B=0, CARRY=0, HALT=0.
//  2 ROM: 0:MOV A,9; 1:ADD A,8; 2:JNC 0.
//    -> after tick 2: A=1, CARRY=1; tick 3 falls through: PC=3.
//  3 ROM: 0:ADD A,1; 1:JNC 0, RUN=1.
//    -> loops; A counts 1..F, then 0 with C=1 at 16th ADD; exits to PC=2.
//  4 ROM: 0:IN B; 1:OUT B; 2:JMP 2, IN=4'hA.
//    -> OUT=A after tick 2; HALT=1 after tick 3, PC stays 2.
//  5 CLK_DIV=3, ROM 0:OUT 5.
//    -> OUT changes 3 cycles after RST release.
//    RUN=0 for 5 cycles mid-count -> no state change; count resumes.
//  6 RST asserted at a tick edge with PC=7 -> next cycle PC=0, counter=0; instruction at 7 not executed.

Source files
------------

// File: rtl/cpu_core.sv
// 4-bit execute core: fetches from a 16x8 ROM at PC and executes one instruction per
// execute tick; the tick is RUN-gated and divided down from CLK by CLK_DIV.
module cpu_core #(
  parameter int CLK_DIV = 1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RUN,
  output logic [3:0] ADDR,
  input  logic [7:0] DATA,
  input  logic [3:0] IN,
  output logic [3:0] OUT,
  output logic       CARRY,
  output logic       HALT,
  output logic [3:0] REG_A,
  output logic [3:0] REG_B
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

  typedef enum logic [3:0] {
    OP_ADD_A  = 4'b0000,
    OP_MOV_AB = 4'b0001,
    OP_IN_A   = 4'b0010,
    OP_MOV_AI = 4'b0011,
    OP_MOV_BA = 4'b0100,
    OP_ADD_B  = 4'b0101,
    OP_IN_B   = 4'b0110,
    OP_MOV_BI = 4'b0111,
    OP_OUT_B  = 4'b1001,
    OP_OUT_I  = 4'b1011,
    OP_JNC    = 4'b1110,
    OP_JMP    = 4'b1111
  } opcode_e;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       pc_q, pc_d;
  logic [3:0]       a_q, a_d;
  logic [3:0]       b_q, b_d;
  logic [3:0]       out_q, out_d;
  logic             c_q, c_d;
  logic             halt_q, halt_d;

  logic             tick;
  logic [3:0]       im;
  logic [3:0]       pc_inc;
  logic [4:0]       sum_a, sum_b;

  assign tick   = RUN && (cnt_q == CNT_MAX);
  assign im     = DATA[3:0];
  assign pc_inc = pc_q + 4'd1;
  assign sum_a  = {1'b0, a_q} + {1'b0, im};
  assign sum_b  = {1'b0, b_q} + {1'b0, im};

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    cnt_d  = cnt_q;
    pc_d   = pc_q;
    a_d    = a_q;
    b_d    = b_q;
    out_d  = out_q;
    c_d    = c_q;
    halt_d = halt_q;

    if (RUN) begin
      cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
    end

    if (tick) begin
      pc_d = pc_inc;
      c_d  = 1'b0;
      case (opcode_e'(DATA[7:4]))
        OP_ADD_A:  begin a_d = sum_a[3:0]; c_d = sum_a[4]; end
        OP_ADD_B:  begin b_d = sum_b[3:0]; c_d = sum_b[4]; end
        OP_MOV_AI: a_d = im;
        OP_MOV_BI: b_d = im;
        OP_MOV_AB: a_d = b_q;
        OP_MOV_BA: b_d = a_q;
        OP_IN_A:   a_d = IN;
        OP_IN_B:   b_d = IN;
        OP_OUT_B:  out_d = b_q;
        OP_OUT_I:  out_d = im;
        OP_JMP:    pc_d = im;
        // JNC looks at the carry as it stood before this tick.
        OP_JNC:    pc_d = c_q ? pc_inc : im;
        default:   ;
      endcase
      halt_d = (pc_d == pc_q);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q  <= '0;
      pc_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      out_q  <= '0;
      c_q    <= 1'b0;
      halt_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      pc_q   <= pc_d;
      a_q    <= a_d;
      b_q    <= b_d;
      out_q  <= out_d;
      c_q    <= c_d;
      halt_q <= halt_d;
    end
  end

  assign ADDR  = pc_q;
  assign OUT   = out_q;
  assign CARRY = c_q;
  assign HALT  = halt_q;
  assign REG_A = a_q;
  assign REG_B = b_q;

endmodule
